// File: rtl/uart_host_port.sv
// uart_host_port: bridges host valid/ready streams onto 4-phase req/ack links to a UART.
// Two initiators (TX, CONF) share one FSM module; a responder feeds an FWFT RX FIFO.

module uart_host_port_init #(
    parameter int SYNC_STAGE = 2,
    parameter int WIDTH      = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             valid,
    output logic             ready,
    input  logic [WIDTH-1:0] data,
    output logic             req,
    input  logic             ack,
    output logic [WIDTH-1:0] async_data
);
    // req is bit 0 of the state flop so the async output cannot glitch
    typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, REL = 2'b10} state_t;

    state_t                state_q, state_d;
    logic [SYNC_STAGE-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]      data_q, data_d;
    logic                  ack_s;

    assign ack_s = sync_q[SYNC_STAGE-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            sync_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (valid && ready) state_d = REQ;
            REQ:     if (ack_s) state_d = REL;
            REL:     if (!ack_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sync_d = {sync_q[SYNC_STAGE-2:0], ack};
        data_d = data_q;
        if (valid && ready) data_d = data;
    end

    // a stale ack seen in IDLE blocks new requests until it drops
    always_comb begin
        ready      = (state_q == IDLE) && !ack_s && !reset;
        req        = state_q[0];
        async_data = data_q;
    end
endmodule

module uart_host_port #(
    parameter int SYNC_STAGE      = 2,
    parameter int UART_DATA_WIDTH = 8,
    parameter int CONFIG_WIDTH    = 8,
    parameter int RX_DEPTH        = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    input  logic [UART_DATA_WIDTH-1:0] tx_data,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    output logic [UART_DATA_WIDTH-1:0] rx_data,
    output logic                       rx_perr,
    input  logic                       conf_valid,
    output logic                       conf_ready,
    input  logic [CONFIG_WIDTH-1:0]    conf_data,
    output logic                       async_tx_d_req,
    input  logic                       async_tx_d_ack,
    output logic [UART_DATA_WIDTH-1:0] async_tx_d,
    input  logic                       async_rx_d_req,
    output logic                       async_rx_d_ack,
    input  logic [UART_DATA_WIDTH:0]   async_rx_d,
    output logic                       async_conf_req,
    input  logic                       async_conf_ack,
    output logic [CONFIG_WIDTH-1:0]    async_conf
);
    localparam int             AW       = $clog2(RX_DEPTH);
    localparam int             EW       = UART_DATA_WIDTH + 1;
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(RX_DEPTH);

    uart_host_port_init #(.SYNC_STAGE(SYNC_STAGE), .WIDTH(UART_DATA_WIDTH)) u_tx (
        .clock(clock), .reset(reset),
        .valid(tx_valid), .ready(tx_ready), .data(tx_data),
        .req(async_tx_d_req), .ack(async_tx_d_ack), .async_data(async_tx_d)
    );

    uart_host_port_init #(.SYNC_STAGE(SYNC_STAGE), .WIDTH(CONFIG_WIDTH)) u_conf (
        .clock(clock), .reset(reset),
        .valid(conf_valid), .ready(conf_ready), .data(conf_data),
        .req(async_conf_req), .ack(async_conf_ack), .async_data(async_conf)
    );

    // ack is bit 0 of the responder state, same reasoning as the initiators
    typedef enum logic [1:0] {WAIT = 2'b00, ACK = 2'b01, DROP = 2'b10} rx_state_t;

    rx_state_t             rx_state_q, rx_state_d;
    logic [SYNC_STAGE-1:0] rx_sync_q, rx_sync_d;
    logic [EW-1:0]         mem_q [RX_DEPTH];
    logic [EW-1:0]         mem_d [RX_DEPTH];
    logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  req_s, full, push, pop;

    assign req_s = rx_sync_q[SYNC_STAGE-1];
    assign full  = (count_q == FULL_CNT);
    assign push  = (rx_state_q == WAIT) && req_s && !full;
    assign pop   = rx_valid && rx_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state_q <= WAIT;
            rx_sync_q  <= '0;
            mem_q      <= '{default: '0};
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_sync_q  <= rx_sync_d;
            mem_q      <= mem_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        unique case (rx_state_q)
            WAIT:    if (push) rx_state_d = ACK;
            ACK:     if (!req_s) rx_state_d = DROP;
            DROP:    rx_state_d = WAIT;
            default: rx_state_d = WAIT;
        endcase
    end

    always_comb begin
        rx_sync_d = {rx_sync_q[SYNC_STAGE-2:0], async_rx_d_req};
        mem_d     = mem_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        if (push) begin
            mem_d[wptr_q] = async_rx_d;
            wptr_d        = wptr_q + AW'(1);
        end
        if (pop) rptr_d = rptr_q + AW'(1);
        if (push && !pop) count_d = count_q + (AW+1)'(1);
        if (pop && !push) count_d = count_q - (AW+1)'(1);
    end

    always_comb begin
        async_rx_d_ack = rx_state_q[0];
        rx_valid       = (count_q != '0) && !reset;
        rx_data        = mem_q[rptr_q][UART_DATA_WIDTH-1:0];
        rx_perr        = mem_q[rptr_q][UART_DATA_WIDTH];
    end
endmodule

// File: tb/tb_uart_host_port.sv
// tb_uart_host_port: scoreboard bench with behavioural 4-phase peers
// for the TX, CONF and RX links of uart_host_port.

module tb_uart_host_port;
    localparam int S   = 2;
    localparam int W   = 8;
    localparam int C   = 8;
    localparam int D   = 4;
    localparam int DLY = 3;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         tx_valid = 1'b0;
    logic         tx_ready;
    logic [W-1:0] tx_data = '0;
    logic         rx_valid;
    logic         rx_ready = 1'b0;
    logic [W-1:0] rx_data;
    logic         rx_perr;
    logic         conf_valid = 1'b0;
    logic         conf_ready;
    logic [C-1:0] conf_data = '0;
    logic         async_tx_d_req;
    logic         async_tx_d_ack;
    logic [W-1:0] async_tx_d;
    logic         async_rx_d_req = 1'b0;
    logic         async_rx_d_ack;
    logic [W:0]   async_rx_d = '0;
    logic         async_conf_req;
    logic         async_conf_ack = 1'b0;
    logic [C-1:0] async_conf;
    logic         tx_ack_p = 1'b0;
    logic         tx_force = 1'b0;

    assign async_tx_d_ack = tx_ack_p | tx_force;

    int           n_chk = 0;
    int           n_fail = 0;
    int           tx_done = 0;
    int           conf_done = 0;
    int           rx_acks = 0;
    logic         rx_lat_en = 1'b0;
    logic [W-1:0] tx_sb [$];
    logic [C-1:0] conf_sb [$];
    logic [W:0]   rx_sb [$];
    logic [W:0]   rx_src [$];
    logic [W:0]   rx_exp;

    uart_host_port #(
        .SYNC_STAGE(S), .UART_DATA_WIDTH(W), .CONFIG_WIDTH(C), .RX_DEPTH(D)
    ) dut (
        .clock(clock), .reset(reset),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_perr(rx_perr),
        .conf_valid(conf_valid), .conf_ready(conf_ready),
        .conf_data(conf_data),
        .async_tx_d_req(async_tx_d_req), .async_tx_d_ack(async_tx_d_ack),
        .async_tx_d(async_tx_d),
        .async_rx_d_req(async_rx_d_req), .async_rx_d_ack(async_rx_d_ack),
        .async_rx_d(async_rx_d),
        .async_conf_req(async_conf_req), .async_conf_ack(async_conf_ack),
        .async_conf(async_conf)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // UART-side TX peer: ack DLY cycles after req, release DLY after req drops
    initial begin : tx_peer
        int st = 0;
        int cnt = 0;
        int gap = 100;
        logic [W-1:0] exp = '0;
        forever begin
            tick();
            gap++;
            if (reset) begin
                st = 0;
                tx_ack_p = 1'b0;
            end else begin
                case (st)
                    0: if (async_tx_d_req) begin
                        check_eq("tx_gap", gap >= S + 2, 1);
                        check_eq("tx_sb_nonempty", tx_sb.size() != 0, 1);
                        if (tx_sb.size() != 0) exp = tx_sb.pop_front();
                        check_eq("tx_data", async_tx_d, exp);
                        cnt = 0;
                        st = 1;
                    end
                    1: begin
                        check_eq("tx_hold", async_tx_d, exp);
                        cnt++;
                        if (cnt == DLY) begin
                            tx_ack_p = 1'b1;
                            st = 2;
                        end
                    end
                    2: begin
                        check_eq("tx_hold", async_tx_d, exp);
                        if (!async_tx_d_req) begin
                            cnt = 0;
                            st = 3;
                        end
                    end
                    default: begin
                        check_eq("tx_req_rel", async_tx_d_req, 0);
                        check_eq("tx_hold", async_tx_d, exp);
                        cnt++;
                        if (cnt == DLY) begin
                            tx_ack_p = 1'b0;
                            gap = 0;
                            tx_done++;
                            st = 0;
                        end
                    end
                endcase
            end
        end
    end

    initial begin : conf_peer
        int st = 0;
        int cnt = 0;
        logic [C-1:0] exp = '0;
        forever begin
            tick();
            if (reset) begin
                st = 0;
                async_conf_ack = 1'b0;
            end else begin
                case (st)
                    0: if (async_conf_req) begin
                        check_eq("conf_sb_nonempty", conf_sb.size() != 0, 1);
                        if (conf_sb.size() != 0) exp = conf_sb.pop_front();
                        check_eq("conf_data", async_conf, exp);
                        cnt = 0;
                        st = 1;
                    end
                    1: begin
                        check_eq("conf_hold", async_conf, exp);
                        cnt++;
                        if (cnt == DLY) begin
                            async_conf_ack = 1'b1;
                            st = 2;
                        end
                    end
                    2: begin
                        check_eq("conf_hold", async_conf, exp);
                        if (!async_conf_req) begin
                            cnt = 0;
                            st = 3;
                        end
                    end
                    default: begin
                        check_eq("conf_req_rel", async_conf_req, 0);
                        check_eq("conf_hold", async_conf, exp);
                        cnt++;
                        if (cnt == DLY) begin
                            async_conf_ack = 1'b0;
                            conf_done++;
                            st = 0;
                        end
                    end
                endcase
            end
        end
    end

    // UART-side RX initiator: sends queued characters, expected pushed on req
    initial begin : rx_peer
        int st = 0;
        int t = 0;
        logic [W:0] d;
        forever begin
            tick();
            t++;
            if (reset) begin
                st = 0;
                async_rx_d_req = 1'b0;
            end else begin
                case (st)
                    0: if (rx_src.size() != 0 && !async_rx_d_ack) begin
                        d = rx_src.pop_front();
                        async_rx_d = d;
                        async_rx_d_req = 1'b1;
                        rx_sb.push_back(d);
                        t = 0;
                        st = 1;
                    end
                    1: if (async_rx_d_ack) begin
                        if (rx_lat_en) begin
                            check_eq("rx_ack_lat", t, S + 1);
                            rx_lat_en = 1'b0;
                        end
                        rx_acks++;
                        async_rx_d_req = 1'b0;
                        st = 2;
                    end
                    default: if (!async_rx_d_ack) st = 0;
                endcase
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && rx_valid && rx_ready) begin
            check_eq("rx_sb_nonempty", rx_sb.size() != 0, 1);
            if (rx_sb.size() != 0) begin
                rx_exp = rx_sb.pop_front();
                check_eq("rx_data", {rx_perr, rx_data}, rx_exp);
            end
        end
    end

    task automatic send_tx(input logic [W-1:0] d);
        int n = 0;
        tx_data = d;
        tx_valid = 1'b1;
        while (!tx_ready && n < 200) begin
            tick();
            n++;
        end
        check_eq("tx_accept", n < 200, 1);
        if (n < 200) tx_sb.push_back(d);
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic send_conf(input logic [C-1:0] d);
        int n = 0;
        conf_data = d;
        conf_valid = 1'b1;
        while (!conf_ready && n < 200) begin
            tick();
            n++;
        end
        check_eq("conf_accept", n < 200, 1);
        if (n < 200) conf_sb.push_back(d);
        tick();
        conf_valid = 1'b0;
    endtask

    initial begin : watchdog
        repeat (30000) @(posedge clock);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        reset = 1'b1;
        repeat (3) tick();
        check_eq("rst_tx_ready", tx_ready, 0);
        check_eq("rst_conf_ready", conf_ready, 0);
        check_eq("rst_rx_valid", rx_valid, 0);
        check_eq("rst_tx_req", async_tx_d_req, 0);
        check_eq("rst_conf_req", async_conf_req, 0);
        check_eq("rst_rx_ack", async_rx_d_ack, 0);
        check_eq("rst_tx_d", async_tx_d, 0);
        check_eq("rst_conf_d", async_conf, 0);
        reset = 1'b0;
        tick();
        check_eq("post_rst_tx_ready", tx_ready, 1);
        check_eq("post_rst_conf_ready", conf_ready, 1);

        send_conf(8'h68);
        n = 0;
        while ((conf_done < 1 || !conf_ready) && n < 200) begin
            tick();
            n++;
        end
        check_eq("conf_done", conf_done, 1);
        check_eq("conf_ready_back", conf_ready, 1);

        send_tx(8'hA5);
        send_tx(8'h3C);
        n = 0;
        while ((tx_done < 2 || !tx_ready) && n < 300) begin
            tick();
            n++;
        end
        check_eq("tx_b2b_done", tx_done, 2);

        rx_ready = 1'b1;
        rx_lat_en = 1'b1;
        rx_src.push_back(9'h15A);
        n = 0;
        while ((rx_acks < 1 || rx_sb.size() != 0 || async_rx_d_ack) && n < 200) begin
            tick();
            n++;
        end
        check_eq("rx_one_acked", rx_acks, 1);
        check_eq("rx_one_drained", rx_valid, 0);

        rx_ready = 1'b0;
        rx_src.push_back(9'h011);
        rx_src.push_back(9'h122);
        rx_src.push_back(9'h033);
        rx_src.push_back(9'h144);
        rx_src.push_back(9'h055);
        repeat (80) tick();
        check_eq("rx_full_acks", rx_acks, 1 + D);
        check_eq("rx_5th_req_held", async_rx_d_req, 1);
        check_eq("rx_5th_unacked", async_rx_d_ack, 0);
        check_eq("rx_full_valid", rx_valid, 1);
        check_eq("rx_full_head", {rx_perr, rx_data}, 9'h011);
        rx_ready = 1'b1;
        n = 0;
        while ((rx_acks < 6 || rx_sb.size() != 0 || rx_valid) && n < 300) begin
            tick();
            n++;
        end
        check_eq("rx_5th_acked", rx_acks, 6);

        tx_force = 1'b1;
        repeat (S + 2) tick();
        tx_data = 8'h77;
        tx_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check_eq("tx_ready_stale_ack", tx_ready, 0);
            tick();
        end
        tx_force = 1'b0;
        send_tx(8'h77);
        n = 0;
        while (tx_done < 3 && n < 200) begin
            tick();
            n++;
        end
        check_eq("tx_after_stale", tx_done, 3);

        send_tx(8'hC3);
        n = 0;
        while (!async_tx_d_req && n < 50) begin
            tick();
            n++;
        end
        check_eq("tx_req_before_rst", async_tx_d_req, 1);
        reset = 1'b1;
        tick();
        check_eq("midrst_req", async_tx_d_req, 0);
        check_eq("midrst_tx_ready", tx_ready, 0);
        check_eq("midrst_tx_d", async_tx_d, 0);
        reset = 1'b0;
        tick();
        check_eq("midrst_tx_ready_back", tx_ready, 1);

        rx_src.push_back(9'h0AB);
        send_tx(8'h96);
        send_conf(8'h1F);
        n = 0;
        while ((tx_done < 4 || conf_done < 2 || rx_acks < 7 || rx_sb.size() != 0) && n < 400) begin
            tick();
            n++;
        end
        check_eq("conc_tx_done", tx_done, 4);
        check_eq("conc_conf_done", conf_done, 2);
        check_eq("conc_rx_acks", rx_acks, 7);
        check_eq("end_tx_sb", tx_sb.size(), 0);
        check_eq("end_conf_sb", conf_sb.size(), 0);
        check_eq("end_rx_sb", rx_sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
